joybus_rx: RTL and testbench

- Joybus receiver. Samples the single-wire Gamecube controller data line, which arrives as the raw GPIO input pad.
- Decodes pulse-width-encoded bits. Delivers each complete frame, either a console command or a controller report, as a parallel word.
- Sits directly upstream of the Gamecube top-level logic, which consumes `frame_valid`/`frame_data` to drive the LEDs and the console-side response path.

---
 rtl/joybus_rx.sv | 182 ++++++++++++++++++
 tb/tb_joybus_rx.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/joybus_rx.sv
// Joybus (Gamecube controller) single-wire receiver.
// Samples the raw open-drain data pad, measures the low time of each bit cell
// and delivers a complete frame (console command or controller report) as a
// right-aligned parallel word once the line has stayed high long enough.
//
// Ports
//   CLOCK_50     system clock, all logic on its rising edge
//   RESET_N      asynchronous active-low reset
//   data_in      raw joybus pad (idles high, asynchronous)
//   frame_valid  one-cycle pulse, good frame in frame_data/frame_bits
//   frame_data   received data bits, first bit received is the MSB
//   frame_bits   number of valid bits in frame_data
//   frame_err    one-cycle pulse, frame aborted
//   err_code     1 stuck low, 2 bad stop bit, 3 overflow
//   busy         frame in progress
//
// state     | meaning
// WAIT_HIGH | after reset / stuck-low, wait for the line to be high
// IDLE      | line high, waiting for the first falling edge
// LOW       | timing the low phase of a bit cell
// HIGH      | timing the high phase; long enough high ends the frame
module joybus_rx #(
   parameter int THRESH   = 100,
   parameter int LOW_MAX  = 250,
   parameter int TIMEOUT  = 400,
   parameter int MAX_BITS = 64
) (
   input  logic                              CLOCK_50,
   input  logic                              RESET_N,
   input  logic                              data_in,
   output logic                              frame_valid,
   output logic [MAX_BITS-1:0]               frame_data,
   output logic [$clog2(MAX_BITS+1)-1:0]     frame_bits,
   output logic                              frame_err,
   output logic [1:0]                        err_code,
   output logic                              busy
);

   localparam int LW = $clog2(LOW_MAX+1);
   localparam int HW = $clog2(TIMEOUT+1);
   localparam int BW = $clog2(MAX_BITS+1);
   localparam int CW = $clog2(MAX_BITS+3);

   typedef enum logic [1:0] {
      WAIT_HIGH = 2'd0,
      IDLE      = 2'd1,
      LOW       = 2'd2,
      HIGH      = 2'd3
   } state_t;

   state_t            state, state_nxt;
   logic              sync1, sync2, sync_d;
   logic              fall, rise;
   logic [LW-1:0]     low_cnt, low_nxt, low_inc;
   logic [HW-1:0]     high_cnt, high_nxt, high_inc;
   logic [CW-1:0]     bit_cnt;
   logic [MAX_BITS:0] shift_reg;
   logic              new_bit;
   logic              shift_en, end_frame, err_stuck;

   // Two-flop synchronizer plus one delayed copy for edge detection.
   // All reset high so the idle line does not look like an edge.
   always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
      if (!RESET_N) begin
         sync1  <= 1'b1;
         sync2  <= 1'b1;
         sync_d <= 1'b1;
      end else begin
         sync1  <= data_in;
         sync2  <= sync1;
         sync_d <= sync2;
      end
   end

   assign fall = sync_d & ~sync2;
   assign rise = ~sync_d & sync2;

   always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
      if (!RESET_N) begin
         state    <= WAIT_HIGH;
         low_cnt  <= '0;
         high_cnt <= '0;
      end else begin
         state    <= state_nxt;
         low_cnt  <= low_nxt;
         high_cnt <= high_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      low_nxt   = low_cnt;
      high_nxt  = high_cnt;
      shift_en  = 1'b0;
      end_frame = 1'b0;
      err_stuck = 1'b0;
      low_inc   = (low_cnt == LW'(LOW_MAX)) ? low_cnt : low_cnt + 1'b1;
      high_inc  = (high_cnt == HW'(TIMEOUT)) ? high_cnt : high_cnt + 1'b1;
      // Judge the bit on the incremented count so that it equals the number
      // of cycles the line was low (a 100-cycle low decodes as 0).
      new_bit   = (low_inc < LW'(THRESH));
      case (state)
         WAIT_HIGH: begin
            if (sync2) state_nxt = IDLE;
         end
         IDLE: begin
            if (fall) begin
               state_nxt = LOW;
               low_nxt   = '0;
            end
         end
         LOW: begin
            low_nxt = low_inc;
            if (rise) begin
               shift_en  = 1'b1;
               state_nxt = HIGH;
               high_nxt  = '0;
            end else if (low_inc == LW'(LOW_MAX)) begin
               err_stuck = 1'b1;
               state_nxt = WAIT_HIGH;
            end
         end
         HIGH: begin
            high_nxt = high_inc;
            if (fall) begin
               state_nxt = LOW;
               low_nxt   = '0;
            end else if (high_inc == HW'(TIMEOUT)) begin
               end_frame = 1'b1;
               state_nxt = IDLE;
            end
         end
         default: state_nxt = WAIT_HIGH;
      endcase
   end

   always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
      if (!RESET_N) begin
         bit_cnt     <= '0;
         shift_reg   <= '0;
         frame_valid <= 1'b0;
         frame_err   <= 1'b0;
         frame_data  <= '0;
         frame_bits  <= '0;
         err_code    <= 2'd0;
         busy        <= 1'b0;
      end else begin
         frame_valid <= 1'b0;
         frame_err   <= 1'b0;
         busy        <= (state_nxt != IDLE);
         if (shift_en) begin
            // Bits past MAX_BITS+1 are dropped; bit_cnt still flags overflow.
            if (bit_cnt <= CW'(MAX_BITS))
               shift_reg <= {shift_reg[MAX_BITS-1:0], new_bit};
            if (bit_cnt != CW'(MAX_BITS+2))
               bit_cnt <= bit_cnt + 1'b1;
         end
         if (err_stuck) begin
            frame_err <= 1'b1;
            err_code  <= 2'd1;
            bit_cnt   <= '0;
            shift_reg <= '0;
         end
         if (end_frame) begin
            if (bit_cnt > CW'(MAX_BITS+1)) begin
               frame_err <= 1'b1;
               err_code  <= 2'd3;
            end else if (!shift_reg[0]) begin
               frame_err <= 1'b1;
               err_code  <= 2'd2;
            end else begin
               frame_valid <= 1'b1;
               frame_bits  <= BW'(bit_cnt - 1'b1);
               frame_data  <= shift_reg[MAX_BITS:1];
            end
            bit_cnt   <= '0;
            shift_reg <= '0;
         end
      end
   end

endmodule

// File: tb/tb_joybus_rx.sv
module tb_joybus_rx;

   localparam int THRESH   = 100;
   localparam int LOW_MAX  = 250;
   localparam int MAX_BITS = 64;

   logic        CLOCK_50 = 1'b0;
   logic        RESET_N  = 1'b0;
   logic        data_in  = 1'b1;
   logic        frame_valid;
   logic [63:0] frame_data;
   logic [6:0]  frame_bits;
   logic        frame_err;
   logic [1:0]  err_code;
   logic        busy;

   joybus_rx dut (
      .CLOCK_50    (CLOCK_50),
      .RESET_N     (RESET_N),
      .data_in     (data_in),
      .frame_valid (frame_valid),
      .frame_data  (frame_data),
      .frame_bits  (frame_bits),
      .frame_err   (frame_err),
      .err_code    (err_code),
      .busy        (busy)
   );

   always #10 CLOCK_50 = ~CLOCK_50;

   typedef struct {
      bit          is_err;
      int          code;
      int          nbits;
      logic [63:0] data;
   } exp_t;

   exp_t exp_q[$];
   int   lows[$];
   int   highs[$];
   int   n_vec  = 0;
   int   n_miss = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      n_vec++;
      if (act !== req) begin
         n_miss++;
         $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
      end
   endtask

   // Reference: decode a frame from its low-phase lengths.
   function automatic exp_t model(input int lo[$]);
      exp_t e;
      int   n;
      e.is_err = 1'b0;
      e.code   = 0;
      e.nbits  = 0;
      e.data   = '0;
      n = lo.size();
      foreach (lo[i]) begin
         if (lo[i] >= LOW_MAX) begin
            e.is_err = 1'b1;
            e.code   = 1;
            return e;
         end
      end
      if (n > MAX_BITS + 1) begin
         e.is_err = 1'b1;
         e.code   = 3;
      end else if (lo[n-1] >= THRESH) begin
         e.is_err = 1'b1;
         e.code   = 2;
      end else begin
         e.nbits = n - 1;
         for (int i = 0; i < n - 1; i++)
            e.data = (e.data << 1) | ((lo[i] < THRESH) ? 64'd1 : 64'd0);
      end
      return e;
   endfunction

   // Monitor / scoreboard
   initial begin
      forever begin
         @(negedge CLOCK_50);
         if (RESET_N) begin
            if (frame_valid && frame_err) begin
               n_vec++;
               n_miss++;
               $display("FAIL pulse_overlap: valid=1 err=1, required at most one");
            end
            if (frame_valid || frame_err) begin
               if (exp_q.size() == 0) begin
                  n_vec++;
                  n_miss++;
                  $display("FAIL unexpected_pulse: valid=%0b err=%0b code=%0d bits=%0d, required none",
                           frame_valid, frame_err, err_code, frame_bits);
               end else begin
                  exp_t e;
                  e = exp_q.pop_front();
                  check("pulse_is_err", 64'(frame_err), 64'(e.is_err));
                  if (e.is_err)
                     check("err_code", 64'(err_code), 64'(e.code));
                  else begin
                     check("frame_bits", 64'(frame_bits), 64'(e.nbits));
                     check("frame_data", frame_data, e.data);
                  end
               end
            end
         end
      end
   end

   task automatic phase(input bit v, input int cyc);
      data_in = v;
      repeat (cyc) @(posedge CLOCK_50);
      #1;
   endtask

   task automatic add_bit(input bit b, input int lo1, input int lo0);
      lows.push_back(b ? lo1 : lo0);
      highs.push_back(b ? 150 : 50);
   endtask

   task automatic add_word(input logic [63:0] v, input int n, input int lo1, input int lo0);
      for (int i = n - 1; i >= 0; i--) add_bit(v[i], lo1, lo0);
   endtask

   task automatic wait_drain(input string name);
      int k;
      k = 0;
      while (exp_q.size() != 0 && k < 300) begin
         @(posedge CLOCK_50);
         k++;
      end
      #1;
      if (exp_q.size() != 0) begin
         n_vec++;
         n_miss++;
         $display("FAIL %s_timeout: %0d expected pulses missing, required 0", name, exp_q.size());
         exp_q.delete();
      end
   endtask

   // Push the model's expectation, drive the frame, check busy drops in time.
   task automatic send_frame(input string name);
      exp_q.push_back(model(lows));
      highs[highs.size()-1] = 410;
      foreach (lows[i]) begin
         phase(1'b0, lows[i]);
         phase(1'b1, highs[i]);
      end
      check({name, "_busy"}, 64'(busy), 64'd0);
      wait_drain(name);
      phase(1'b1, 100);
      lows.delete();
      highs.delete();
   endtask

   task automatic check_zero_outputs(input string name);
      check({name, "_valid"}, 64'(frame_valid), 64'd0);
      check({name, "_err"},   64'(frame_err), 64'd0);
      check({name, "_data"},  frame_data, 64'd0);
      check({name, "_bits"},  64'(frame_bits), 64'd0);
      check({name, "_code"},  64'(err_code), 64'd0);
      check({name, "_busy"},  64'(busy), 64'd0);
   endtask

   initial begin
      logic [63:0] rv;
      int          n;
      @(posedge CLOCK_50);
      #1;
      RESET_N = 1'b0;
      phase(1'b1, 5);
      RESET_N = 1'b1;
      phase(1'b1, 5);
      check_zero_outputs("reset");
      phase(1'b1, 500);

      // Poll command
      add_word(64'h400300, 24, 50, 150);
      add_bit(1'b1, 50, 150);
      send_frame("poll");

      // Full-size report
      add_word(64'h00808080801F1F00, 64, 50, 150);
      add_bit(1'b1, 50, 150);
      send_frame("report");

      // Threshold boundary: 99 low -> 1, 100 low -> 0
      add_word(64'hA5, 8, 99, 100);
      add_bit(1'b1, 50, 150);
      send_frame("thresh");

      // Stop-bit-only frame
      add_bit(1'b1, 50, 150);
      send_frame("stop_only");

      // Stuck low, then recovery
      begin
         exp_t e;
         e.is_err = 1'b1;
         e.code   = 1;
         e.nbits  = 0;
         e.data   = '0;
         exp_q.push_back(e);
      end
      phase(1'b0, 300);
      phase(1'b1, 100);
      wait_drain("stuck");
      check("stuck_busy", 64'(busy), 64'd0);
      phase(1'b1, 400);
      add_word(64'hA5, 8, 50, 150);
      add_bit(1'b1, 50, 150);
      send_frame("recover");

      // Bad stop bit
      add_word(64'h3C, 8, 50, 150);
      add_bit(1'b0, 50, 150);
      send_frame("bad_stop");

      // Overflow: 65 data bits + stop
      add_bit(1'b1, 50, 150);
      add_word({$urandom, $urandom}, 64, 50, 150);
      add_bit(1'b1, 50, 150);
      send_frame("overflow");

      // Reset in the middle of a frame
      add_word(64'h2D5, 10, 50, 150);
      foreach (lows[i]) begin
         phase(1'b0, lows[i]);
         phase(1'b1, highs[i]);
      end
      lows.delete();
      highs.delete();
      RESET_N = 1'b0;
      phase(1'b1, 5);
      RESET_N = 1'b1;
      phase(1'b1, 5);
      check_zero_outputs("midreset");
      phase(1'b1, 500);
      add_word(64'hA5, 8, 50, 150);
      add_bit(1'b1, 50, 150);
      send_frame("after_reset");

      // Randomized frames with jittered timing
      for (int f = 0; f < 5; f++) begin
         n  = $urandom_range(0, 16);
         rv = {$urandom, $urandom};
         for (int i = 0; i < n; i++) begin
            lows.push_back(rv[i] ? $urandom_range(20, 99) : $urandom_range(100, 200));
            highs.push_back($urandom_range(30, 200));
         end
         lows.push_back(($urandom_range(0, 3) != 0) ? $urandom_range(20, 99) : $urandom_range(100, 200));
         highs.push_back(410);
         send_frame("random");
      end

      wait_drain("final");
      check("queue_empty", 64'(exp_q.size()), 64'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
